// File: rtl/mux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_pkg
// Description : Shared constants for the 8:1 mux scan controller: FSM state
//               encodings, default settle time, address and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_ctrl_pkg;

    // Address width of the scanned mux (8 inputs).
    localparam int unsigned c_addr_w         = 3;
    // Default number of wait cycles between driving selects and sampling Y.
    localparam int unsigned c_settle_default = 1;
    // Settle counter width; covers the full 0..15 SETTLE range.
    localparam int unsigned c_cnt_w          = 4;

    // FSM state encodings.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [c_addr_w-1:0] c_addr_last = 3'd7;
    localparam logic [c_addr_w-1:0] c_addr_one  = 3'd1;
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = 4'd1;

    // First address of a scan: zero for a full scan, the target otherwise.
    function automatic logic [c_addr_w-1:0] first_addr(
        input logic                single,
        input logic [c_addr_w-1:0] target
    );
        return single ? target : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : mux_settle_timer
// Description : Settle down-counter. Loads SETTLE on load, counts down by one
//               per enabled cycle and parks at zero.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset (count cleared)
//               load - reload the count with SETTLE (wins over dec)
//               dec  - decrement enable (ignored when count is zero)
//               zero - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module mux_settle_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = c_settle_default
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_cnt_w'(SETTLE);
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - c_cnt_one;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Scans an external 8:1 mux. Drives the select lines, waits
//               SETTLE cycles per address, samples Y into CAPTURE[address].
//               Full scan covers addresses 0..7; single mode one address.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               start      - scan request, honoured only in IDLE
//               abort      - cancel the scan (wins over start and sampling)
//               mode       - 0 = full scan, 1 = single address
//               addr[2:0]  - target address for single mode
//               y          - mux output being scanned
//               s0,s1,s2   - mux selects, {s0,s1,s2} = address (s0 MSB)
//               busy       - high in SCAN and DONE
//               done       - one-cycle completion pulse
//               valid      - capture holds a complete result
//               capture    - bit i = Y sampled at address i
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = c_settle_default
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                mode,
    input  logic [c_addr_w-1:0] addr,
    input  logic                y,
    output logic                s0,
    output logic                s1,
    output logic                s2,
    output logic                busy,
    output logic                done,
    output logic                valid,
    output logic [7:0]          capture
);

    logic [1:0]          r_state;
    logic [c_addr_w-1:0] r_addr;
    logic                r_single;
    logic                r_valid;
    logic [7:0]          r_capture;

    logic w_accept;
    logic w_in_scan;
    logic w_sample;
    logic w_last;
    logic w_advance;
    logic w_zero;

    assign w_in_scan = (r_state == c_st_scan);
    assign w_accept  = (r_state == c_st_idle) && start && !abort;
    // A sample edge is a SCAN edge with the settle count exhausted; abort
    // on that same edge suppresses the sample.
    assign w_sample  = w_in_scan && !abort && w_zero;
    assign w_last    = r_single || (r_addr == c_addr_last);
    assign w_advance = w_sample && !w_last;

    // Reloading on every address advance gives each address exactly
    // SETTLE+1 cycles: SETTLE counting cycles plus the sampling cycle.
    mux_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept || w_advance),
        .dec  (w_in_scan && !abort),
        .zero (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_addr    <= '0;
            r_single  <= 1'b0;
            r_valid   <= 1'b0;
            r_capture <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state   <= c_st_scan;
                        r_addr    <= first_addr(mode, addr);
                        r_single  <= mode;
                        r_valid   <= 1'b0;
                        r_capture <= 8'h00;
                    end
                end
                c_st_scan: begin
                    if (abort) begin
                        // Partial capture bits are deliberately kept.
                        r_state <= c_st_idle;
                    end else if (w_sample) begin
                        r_capture[r_addr] <= y;
                        if (w_last) begin
                            r_state <= c_st_done;
                        end else begin
                            r_addr <= r_addr + c_addr_one;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    if (!abort) begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign s0      = r_addr[2];
    assign s1      = r_addr[1];
    assign s2      = r_addr[0];
    assign busy    = (r_state == c_st_scan) || (r_state == c_st_done);
    assign done    = (r_state == c_st_done);
    assign valid   = r_valid;
    assign capture = r_capture;

endmodule
`default_nettype wire

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 0..15: wait cycles between driving the select lines and sampling Y.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port START, input, 1 bit: request a scan; sampled only in IDLE.
REQ-005 The block SHALL have port ABORT, input, 1 bit: cancel the current scan.
REQ-006 The block SHALL have port MODE, input, 1 bit: 0 = full scan of addresses 0..7, 1 = single address.
REQ-007 The block SHALL have port ADDR, input, 3 bits: target address in single mode; captured at START acceptance.
REQ-008 The block SHALL have port Y, input, 1 bit: the mux output being scanned.
REQ-009 The block SHALL have ports S0, S1, S2, each output, 1 bit: mux selects; {S0,S1,S2} = current address, S0 MSB.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high in the SCAN and DONE states.
REQ-011 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse at scan completion.
REQ-012 The block SHALL have port VALID, output, 1 bit: CAPTURE holds a complete result.
REQ-013 The block SHALL have port CAPTURE, output, 8 bits: bit i = Y sampled at address i.

Function
REQ-014 The FSM SHALL have states IDLE, SCAN, DONE, encoded as registered state.
REQ-015 IDLE with START=1 and ABORT=0 at an edge SHALL move to SCAN; the same edge SHALL load the address (0 if MODE=0, else ADDR), load the settle count with SETTLE, clear CAPTURE and clear VALID.
REQ-016 In SCAN with a nonzero count, each edge SHALL decrement the count.
REQ-017 In SCAN with a zero count, the edge SHALL write Y into CAPTURE[address].
REQ-018 After a sampling edge in a full scan with address < 7, the address SHALL increment and the count SHALL reload with SETTLE.
REQ-019 After a sampling edge at the last address (address 7 in a full scan, or the single address), the next state SHALL be DONE.
REQ-020 Each address SHALL occupy exactly SETTLE+1 cycles in SCAN, and S0..S2 SHALL be stable throughout those cycles.
REQ-021 DONE SHALL last one cycle, with DONE=1 and VALID set at the edge leaving DONE; the next state SHALL be IDLE.
REQ-022 Latency from the START-accept edge to DONE high SHALL be 8*(SETTLE+1) cycles for a full scan and SETTLE+1 cycles for a single address.
REQ-023 START SHALL be ignored while not in IDLE; MODE and ADDR changes during a scan SHALL have no effect.
REQ-024 ABORT=1 in SCAN or DONE SHALL force IDLE at the next edge; DONE SHALL not pulse and VALID SHALL stay 0; partial CAPTURE bits SHALL be retained.
REQ-025 ABORT and START both high in IDLE SHALL leave the FSM in IDLE (ABORT wins).
REQ-026 ABORT at the sampling edge SHALL take priority: no sample is written and the FSM returns to IDLE.
REQ-027 In IDLE, S0..S2 SHALL hold the last address driven, and VALID and CAPTURE SHALL hold until the next accepted START.
REQ-028 The address counter SHALL never wrap: the increment is suppressed at address 7.

Reset
REQ-029 Asserting RST SHALL immediately and asynchronously force state=IDLE, S0=S1=S2=0, BUSY=0, DONE=0, VALID=0, CAPTURE=8'h00, count=0.
REQ-030 Reset mid-scan SHALL discard the scan; the first START after release SHALL behave as from power-up.

Structure
REQ-031 The state encodings, the SETTLE default and the address width (3) SHALL live in the shared lab include/package file.
REQ-032 The settle down-counter SHALL be one sub-module, mux_settle_timer, with load, zero flag and SETTLE parameter; the FSM and capture register SHALL stay in mux_scan_ctrl.

Verification
REQ-033 With SETTLE=1, the lab 8:1 mux attached and a full-scan START -> DONE pulses 16 cycles after accept, CAPTURE=8'h39, VALID=1.
REQ-034 With SETTLE=0, MODE=1, ADDR=3 -> DONE after 1 cycle, CAPTURE=8'h08, and S0..S2=011 in the sample cycle.
REQ-035 With SETTLE=3, ABORT asserted at cycle 10 of a full scan -> IDLE next cycle, no DONE, VALID=0, CAPTURE[1:0] retained.
REQ-036 START pulses during BUSY -> no restart and DONE exactly once; START and ABORT together in IDLE -> stays IDLE.
REQ-037 RST asserted mid-scan between clock edges -> outputs are reset values before the next edge; a subsequent full scan returns CAPTURE=8'h39.
REQ-038 A bench checker SHALL confirm that S0..S2 never change except at address-advance edges, and never exceed 7, over randomised SETTLE in 0..15.
